// File: rtl/pagerank_pkg.sv
// Shared types for the PageRank gather stage: rank word, FSM state encoding, saturation limit.
package pagerank_pkg;

    typedef logic [63:0] rank_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2,
        HOLD    = 2'd3
    } gather_state_e;

    localparam rank_t RANK_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/pagerank_acc_add.sv
// 64-bit accumulate adder for the gather RMW path.
// GATHER_SAT_EN selects a saturating add; otherwise the add wraps modulo 2^64.
module pagerank_acc_add
    import pagerank_pkg::*;
(
    input  rank_t a,
    input  rank_t b,
    output rank_t sum
);

`ifdef GATHER_SAT_EN
    logic [64:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[64] ? RANK_MAX : full[63:0];
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/pagerank_gather.sv
// Accumulates per-node contribution sums from the scatter stage and publishes them to
// pagerank_comp. Saturating accumulation is enabled by defining GATHER_SAT_EN.
module pagerank_gather
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_GRAPH = 4,
    parameter int NODE_ID_W      = $clog2(NODES_IN_GRAPH) + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             update_valid,
    output logic                             update_ready,
    input  logic [NODE_ID_W-1:0]             update_dst,
    input  logic [63:0]                      update_value,
    input  logic                             scatter_done,
    input  logic                             nextIteration,
    input  logic                             pagerank_complete,
    output logic [NODES_IN_GRAPH-1:0][63:0]  pagerank_serial_stream,
    output logic                             stream_start,
    output logic                             stream_done,
    output logic [31:0]                      updates_accepted,
    output logic                             err_bad_dst
);

    gather_state_e                    state, state_nxt;
    logic [NODES_IN_GRAPH-1:0][63:0]  sums;
    logic                             xfer;
    logic                             dst_ok;
    logic                             enter_accum;
    rank_t                            add_a, add_sum;

    assign update_ready = (state == ACCUM);
    assign stream_start = (state == PUBLISH);
    assign stream_done  = (state == HOLD);
    assign pagerank_serial_stream = sums;

    assign xfer   = update_valid & update_ready;
    assign dst_ok = update_dst < NODE_ID_W'(NODES_IN_GRAPH);

    // Read side of the single-cycle RMW; out-of-range ids read zero and are never written.
    always_comb begin
        add_a = '0;
        for (int i = 0; i < NODES_IN_GRAPH; i++)
            if (update_dst == NODE_ID_W'(i)) add_a = sums[i];
    end

    pagerank_acc_add u_add (
        .a   (add_a),
        .b   (update_value),
        .sum (add_sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (scatter_done) state_nxt = PUBLISH;
            PUBLISH: state_nxt = HOLD;
            HOLD: begin
                if (pagerank_complete)  state_nxt = IDLE;
                else if (nextIteration) state_nxt = ACCUM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_accum = (state_nxt == ACCUM) && (state != ACCUM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            sums             <= '0;
            updates_accepted <= '0;
            err_bad_dst      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enter_accum) begin
                sums             <= '0;
                updates_accepted <= '0;
            end else if (xfer) begin
                // Accepted even when out of range so the scatter side never stalls.
                updates_accepted <= updates_accepted + 32'd1;
                if (!dst_ok) err_bad_dst <= 1'b1;
                for (int i = 0; i < NODES_IN_GRAPH; i++)
                    if (dst_ok && update_dst == NODE_ID_W'(i)) sums[i] <= add_sum;
            end
        end
    end

endmodule

// File: tb/tb_pagerank_gather.sv
// Scoreboard bench for pagerank_gather: expected vectors are queued at scatter_done and
// compared when stream_start is observed.
module tb_pagerank_gather;

    localparam int N  = 4;
    localparam int IW = $clog2(N) + 1;

    typedef struct packed {
        logic [N-1:0][63:0] s;
        logic [31:0]        n;
        logic               err;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset;
    logic                start, update_valid, scatter_done, nextIteration, pagerank_complete;
    logic                update_ready;
    logic [IW-1:0]       update_dst;
    logic [63:0]         update_value;
    logic [N-1:0][63:0]  pagerank_serial_stream;
    logic                stream_start, stream_done, err_bad_dst;
    logic [31:0]         updates_accepted;

    int n_chk = 0;
    int n_err = 0;

    logic [N-1:0][63:0]  m_sum;
    logic [31:0]         m_cnt;
    logic                m_err;
    exp_t                sb[$];

    always #5 clock = ~clock;

    pagerank_gather #(.NODES_IN_GRAPH(N)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .update_valid           (update_valid),
        .update_ready           (update_ready),
        .update_dst             (update_dst),
        .update_value           (update_value),
        .scatter_done           (scatter_done),
        .nextIteration          (nextIteration),
        .pagerank_complete      (pagerank_complete),
        .pagerank_serial_stream (pagerank_serial_stream),
        .stream_start           (stream_start),
        .stream_done            (stream_done),
        .updates_accepted       (updates_accepted),
        .err_bad_dst            (err_bad_dst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] f;
        f = {1'b0, a} + {1'b0, b};
`ifdef GATHER_SAT_EN
        if (f[64]) return 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        return f[63:0];
    endfunction

    task automatic model_clear();
        m_sum = '0;
        m_cnt = '0;
    endtask

    // Offer one update for a cycle; the block is in ACCUM so it transfers on the next edge.
    task automatic send(input int dst, input logic [63:0] val, input logic last);
        chk("ready", update_ready, 1);
        update_valid = 1'b1;
        update_dst   = IW'(dst);
        update_value = val;
        scatter_done = last;
        m_cnt = m_cnt + 1;
        if (dst < N) m_sum[dst] = model_add(m_sum[dst], val);
        else         m_err = 1'b1;
        if (last) sb.push_back('{s: m_sum, n: m_cnt, err: m_err});
        @(negedge clock);
        update_valid = 1'b0;
        scatter_done = 1'b0;
    endtask

    // Called on the negedge right after the scatter_done edge.
    task automatic expect_publish();
        exp_t e;
        chk("stream_start", stream_start, 1);
        chk("stream_done_pub", stream_done, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) chk($sformatf("sum%0d", i), pagerank_serial_stream[i], e.s[i]);
            chk("count", updates_accepted, e.n);
            chk("err_bad_dst", err_bad_dst, e.err);
        end
        @(negedge clock);
        chk("start_pulse", stream_start, 0);
        chk("stream_done", stream_done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        model_clear();
    endtask

    task automatic next_iter();
        nextIteration = 1'b1;
        @(negedge clock);
        nextIteration = 1'b0;
        model_clear();
        chk("done_drop", stream_done, 0);
        chk("cleared_sum0", pagerank_serial_stream[0], 0);
        chk("cleared_cnt", updates_accepted, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 0; update_valid = 0; scatter_done = 0; nextIteration = 0; pagerank_complete = 0;
        update_dst = '0; update_value = '0;
        m_sum = '0; m_cnt = '0; m_err = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", update_ready, 0);
        chk("rst_start", stream_start, 0);
        chk("rst_done", stream_done, 0);
        chk("rst_cnt", updates_accepted, 0);
        chk("rst_err", err_bad_dst, 0);
        chk("rst_stream", pagerank_serial_stream[0] | pagerank_serial_stream[N-1], 0);

        // 1: one update per node
        pulse_start();
        send(0, 64'd1, 0); send(1, 64'd2, 0); send(2, 64'd3, 0); send(3, 64'd4, 1);
        expect_publish();
        // HOLD ignores offered updates and keeps the vector frozen
        update_valid = 1'b1; update_dst = '0; update_value = 64'd100;
        chk("hold_ready", update_ready, 0);
        @(negedge clock);
        update_valid = 1'b0;
        chk("hold_sum0", pagerank_serial_stream[0], 64'd1);
        chk("hold_cnt", updates_accepted, 32'd4);
        chk("hold_done", stream_done, 1);

        // 2: back-to-back updates to the same node
        next_iter();
        for (int k = 0; k < 5; k++) send(2, 64'd5, k == 4);
        expect_publish();

        // 3: single update after nextIteration
        next_iter();
        send(1, 64'd7, 1);
        expect_publish();

        // 4: out-of-range destination
        next_iter();
        send(6, 64'd9, 1);
        expect_publish();

        // 5: overflow of a single accumulator
        next_iter();
        send(0, 64'hFFFF_FFFF_FFFF_FFF0, 0);
        send(0, 64'h20, 1);
        expect_publish();

        // 6: asynchronous reset mid-pass
        next_iter();
        send(0, 64'd1, 0); send(1, 64'd1, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", update_ready, 0);
        chk("arst_cnt", updates_accepted, 0);
        chk("arst_sum0", pagerank_serial_stream[0], 0);
        chk("arst_err", err_bad_dst, 0);
        @(negedge clock);
        reset = 1'b0;
        m_err = 1'b0;
        model_clear();
        chk("arst_idle", update_ready, 0);

        // scatter_done in IDLE is ignored
        scatter_done = 1'b1;
        @(negedge clock);
        scatter_done = 1'b0;
        @(negedge clock);
        chk("idle_sd_ignored", stream_start, 0);

        pulse_start();
        send(3, 64'd2, 1);
        expect_publish();
        // complete wins over nextIteration
        nextIteration = 1'b1; pagerank_complete = 1'b1;
        @(negedge clock);
        nextIteration = 1'b0; pagerank_complete = 1'b0;
        chk("complete_ready", update_ready, 0);
        chk("complete_done", stream_done, 0);
        @(negedge clock);
        chk("idle_stays", update_ready, 0);
        pulse_start();
        chk("restart_cnt", updates_accepted, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
